// File: rtl/mem_defs.sv
// Shared definitions for the memory port arbiter: FSM states, byte-enable
// constants and response owner encoding.
package mem_defs;

    // IDLE: nothing outstanding; RSP: a response is due this cycle;
    // RMW_WR: the merged word of a partial store is written this cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RSP    = 2'd1,
        ST_RMW_WR = 2'd2
    } arb_state_t;

    localparam logic [3:0] BE_FULL  = 4'hF;
    localparam logic [3:0] BE_NONE  = 4'h0;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // A store that touches some but not all lanes needs a read-modify-write.
    function automatic logic is_partial(input logic [3:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_be_merge.sv
// Byte-lane merge for partial stores: lanes with their enable set take the
// store data, the rest keep the word read back from the RAM.
module be_merge (
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    // Start from the old word and overwrite only the enabled lanes.
    always_comb begin
        merged = rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one word-wide, 1-cycle-latency synchronous RAM between the
// instruction fetch port and the load/store port. Data has priority, with a
// starvation guard that forces a fetch grant after STARVE_MAX consecutive data
// grants. Byte and halfword stores are emulated by read-modify-write.
module mem_port_arbiter
    import mem_defs::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_be,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [CNT_W-1:0]  starve_cnt;

    logic              lat_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_be;
    logic [31:0]       lat_wdata;

    logic              can_issue;
    logic              fetch_forced;
    logic              grant_d;
    logic              grant_if;
    logic [31:0]       merged_word;

    // Grants are only possible in IDLE or RSP and never while reset is held,
    // so nothing reaches the RAM or the ready outputs during reset.
    assign can_issue    = rst_n && ((state == ST_IDLE) || (state == ST_RSP));
    assign fetch_forced = if_req_valid && (starve_cnt == STARVE_LIM);
    assign grant_d      = can_issue && d_req_valid && !fetch_forced;
    assign grant_if     = can_issue && if_req_valid && !grant_d;

    be_merge u_merge (
        .rdata  (ram_dout),
        .wdata  (lat_wdata),
        .be     (lat_be),
        .merged (merged_word)
    );

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and RAM command: accept a new request or finish a partial store.
    always_comb begin
        state_next   = ST_IDLE;
        if_req_ready = grant_if;
        d_req_ready  = grant_d;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_din      = '0;
        case (state)
            ST_RMW_WR: begin
                state_next = ST_RSP;
                ram_we     = 1'b1;
                ram_addr   = lat_addr;
                ram_din    = merged_word;
            end
            default: begin
                if (grant_d) begin
                    ram_addr = d_req_addr;
                    if (d_req_we && (d_req_be == BE_FULL)) begin
                        ram_we  = 1'b1;
                        ram_din = d_req_wdata;
                    end
                    if (d_req_we && is_partial(d_req_be)) begin
                        state_next = ST_RMW_WR;
                    end else begin
                        state_next = ST_RSP;
                    end
                end else if (grant_if) begin
                    ram_addr   = if_req_addr;
                    state_next = ST_RSP;
                end
            end
        endcase
    end

    // Responses go to the latched owner; stores acknowledge with zero data.
    always_comb begin
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        if (state == ST_RSP) begin
            if (lat_owner == OWNER_D) begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = lat_we ? 32'h0 : ram_dout;
            end else begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = ram_dout;
            end
        end
    end

    // Count consecutive data grants while fetch is waiting; saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req_valid || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Capture the accepted request so responses and the RMW write can use it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_owner <= OWNER_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else if (grant_d) begin
            lat_owner <= OWNER_D;
            lat_we    <= d_req_we;
            lat_addr  <= d_req_addr;
            lat_be    <= d_req_be;
            lat_wdata <= d_req_wdata;
        end else if (grant_if) begin
            lat_owner <= OWNER_IF;
            lat_we    <= 1'b0;
            lat_addr  <= if_req_addr;
            lat_be    <= '0;
            lat_wdata <= '0;
        end
    end

endmodule
